// File: rtl/psum_requant_writeback.sv
// Sweeps the partial-sum buffer one pixel per cycle, requantises every lane
// (bias, rounding shift, optional ReLU, int8 saturation) and writes packed words out.
module psum_requant_writeback #(
    parameter int NUM_CH = 16,
    parameter int PSUM_W = 32,
    parameter int ACT_W  = 8,
    parameter int RES_AW = 10,
    parameter int ACT_AW = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [RES_AW:0]            num_pix,
    input  logic [4:0]                 shift,
    input  logic                       relu_en,
    input  logic [NUM_CH*PSUM_W-1:0]   bias_in,
    input  logic [ACT_AW-1:0]          dst_base,
    output logic [RES_AW-1:0]          res_addr,
    input  logic [NUM_CH*PSUM_W-1:0]   res_data,
    output logic                       act_wr_we,
    output logic [ACT_AW-1:0]          act_wr_addr,
    output logic [NUM_CH*ACT_W-1:0]    act_wr_data,
    output logic                       busy,
    output logic                       done
);

    localparam int SUM_W = PSUM_W + 1;
    localparam int RND_W = PSUM_W + 2;
    localparam logic [RES_AW:0] MAX_PIX = {1'b1, {RES_AW{1'b0}}};
    localparam logic signed [RND_W-1:0] SAT_HI = RND_W'((1 <<< (ACT_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] SAT_LO = RND_W'(-(1 <<< (ACT_W - 1)));

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t                     state_q, state_d;
    logic [RES_AW-1:0]          res_addr_q, res_addr_d;
    logic [RES_AW-1:0]          last_q, last_d;
    logic [4:0]                 shift_q, shift_d;
    logic                       relu_q, relu_d;
    logic [NUM_CH*PSUM_W-1:0]   bias_q, bias_d;
    logic [ACT_AW-1:0]          dst_base_q, dst_base_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       pend_q, pend_d;
    logic [RES_AW-1:0]          pend_idx_q, pend_idx_d;
    logic                       s1_valid_q, s1_valid_d;
    logic [ACT_AW-1:0]          s1_addr_q, s1_addr_d;
    logic [NUM_CH*SUM_W-1:0]    s1_sum_q, s1_sum_d;
    logic [RES_AW:0]            pix_clamp;
    logic [RES_AW:0]            pix_last;

    always_comb begin
        state_d    = state_q;
        res_addr_d = res_addr_q;
        last_d     = last_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        bias_d     = bias_q;
        dst_base_d = dst_base_q;
        pix_clamp  = (num_pix > MAX_PIX) ? MAX_PIX : num_pix;
        pix_last   = pix_clamp - {{RES_AW{1'b0}}, 1'b1};

        // pend marks that res_data on the next cycle belongs to the address issued now
        pend_d     = (state_q == S_ISSUE);
        pend_idx_d = res_addr_q;
        s1_valid_d = pend_q;
        s1_addr_d  = dst_base_q + {{(ACT_AW - RES_AW){1'b0}}, pend_idx_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d    = shift;
                    relu_d     = relu_en;
                    bias_d     = bias_in;
                    dst_base_d = dst_base;
                    last_d     = pix_last[RES_AW-1:0];
                    res_addr_d = '0;
                    state_d    = (num_pix == '0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (res_addr_q == last_q) begin
                    state_d = S_DRAIN;
                end else begin
                    res_addr_d = res_addr_q + RES_AW'(1);
                end
            end
            S_DRAIN: begin
                // the final pixel is being written this cycle once nothing is pending
                if (!pend_q) begin
                    state_d = S_FIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            res_addr_q <= '0;
            last_q     <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            bias_q     <= '0;
            dst_base_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_sum_q   <= '0;
        end else begin
            state_q    <= state_d;
            res_addr_q <= res_addr_d;
            last_q     <= last_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
            bias_q     <= bias_d;
            dst_base_q <= dst_base_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s1_sum_q   <= s1_sum_d;
        end
    end

    // The rounding/ReLU/saturate stage is combinational off the bias-sum register so
    // a pixel is written two cycles after its address; data is zeroed when not writing.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
            logic [PSUM_W-1:0]        psum_l;
            logic [PSUM_W-1:0]        bias_l;
            logic signed [RND_W-1:0]  sum_x;
            logic signed [RND_W-1:0]  rnd;
            logic signed [RND_W-1:0]  rnd_sum;
            logic signed [RND_W-1:0]  shifted;
            logic [ACT_W-1:0]         lane_act;

            assign psum_l = res_data[gi*PSUM_W +: PSUM_W];
            assign bias_l = bias_q[gi*PSUM_W +: PSUM_W];
            assign s1_sum_d[gi*SUM_W +: SUM_W] =
                {psum_l[PSUM_W-1], psum_l} + {bias_l[PSUM_W-1], bias_l};

            assign sum_x   = $signed({s1_sum_q[gi*SUM_W + SUM_W - 1], s1_sum_q[gi*SUM_W +: SUM_W]});
            assign rnd     = (shift_q == 5'd0) ? '0 : (RND_W'(1) << (shift_q - 5'd1));
            assign rnd_sum = sum_x + rnd;
            assign shifted = rnd_sum >>> shift_q;

            always_comb begin
                lane_act = shifted[ACT_W-1:0];
                if (relu_q && shifted[RND_W-1]) begin
                    lane_act = '0;
                end else if (shifted > SAT_HI) begin
                    lane_act = SAT_HI[ACT_W-1:0];
                end else if (shifted < SAT_LO) begin
                    lane_act = SAT_LO[ACT_W-1:0];
                end
            end

            assign act_wr_data[gi*ACT_W +: ACT_W] = s1_valid_q ? lane_act : '0;
        end
    endgenerate

    assign res_addr    = res_addr_q;
    assign act_wr_we   = s1_valid_q;
    assign act_wr_addr = s1_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_psum_requant_writeback.sv
// Scoreboard bench: each sweep pushes its expected writes; a negedge monitor pops and compares.
module tb_psum_requant_writeback;

    localparam int NUM_CH = 16;
    localparam int PSUM_W = 32;
    localparam int ACT_W  = 8;
    localparam int RES_AW = 10;
    localparam int ACT_AW = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [RES_AW:0]          num_pix;
    logic [4:0]               shift;
    logic                     relu_en;
    logic [NUM_CH*PSUM_W-1:0] bias_in;
    logic [ACT_AW-1:0]        dst_base;
    logic [RES_AW-1:0]        res_addr;
    logic [NUM_CH*PSUM_W-1:0] res_data;
    logic                     act_wr_we;
    logic [ACT_AW-1:0]        act_wr_addr;
    logic [NUM_CH*ACT_W-1:0]  act_wr_data;
    logic                     busy;
    logic                     done;

    psum_requant_writeback #(
        .NUM_CH(NUM_CH), .PSUM_W(PSUM_W), .ACT_W(ACT_W), .RES_AW(RES_AW), .ACT_AW(ACT_AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_pix(num_pix), .shift(shift),
        .relu_en(relu_en), .bias_in(bias_in), .dst_base(dst_base), .res_addr(res_addr),
        .res_data(res_data), .act_wr_we(act_wr_we), .act_wr_addr(act_wr_addr),
        .act_wr_data(act_wr_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [NUM_CH*PSUM_W-1:0] mem [0:1023];
    always @(posedge clk) res_data <= mem[res_addr];

    int errors = 0;
    int checks = 0;
    logic [ACT_AW-1:0]       exp_addr_q[$];
    logic [NUM_CH*ACT_W-1:0] exp_data_q[$];

    always @(negedge clk) begin : monitor
        logic [ACT_AW-1:0]       ea;
        logic [NUM_CH*ACT_W-1:0] ed;
        if (!rst && act_wr_we) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", act_wr_addr, act_wr_data);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (act_wr_addr !== ea || act_wr_data !== ed) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h", act_wr_addr, act_wr_data, ea, ed);
                end else begin
                    $display("write addr=%h data=%h ok", act_wr_addr, act_wr_data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [NUM_CH*PSUM_W-1:0] psum_lane(input int c, input int val);
        logic [NUM_CH*PSUM_W-1:0] w;
        w = '0;
        w[c*PSUM_W +: PSUM_W] = val;
        return w;
    endfunction

    function automatic logic [NUM_CH*ACT_W-1:0] act_lane(input int c, input logic [7:0] val);
        logic [NUM_CH*ACT_W-1:0] w;
        w = '0;
        w[c*ACT_W +: ACT_W] = val;
        return w;
    endfunction

    // Reference: floor((s + d/2) / d) via integer division, then ReLU and clamp.
    function automatic logic [7:0] model_lane(input longint s, input int sh, input bit relu);
        longint d, num, q;
        logic [63:0] qb;
        d   = longint'(1) << sh;
        num = s + d / 2;
        q   = num / d;
        if ((num % d) != 0 && num < 0) q = q - 1;
        if (relu && q < 0) q = 0;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        qb = q;
        return qb[7:0];
    endfunction

    function automatic logic [NUM_CH*ACT_W-1:0] model_word(input logic [NUM_CH*PSUM_W-1:0] ps,
                                                          input logic [NUM_CH*PSUM_W-1:0] bs,
                                                          input int sh, input bit relu);
        logic [NUM_CH*ACT_W-1:0] w;
        longint s;
        for (int c = 0; c < NUM_CH; c++) begin
            s = longint'($signed(ps[c*PSUM_W +: PSUM_W])) + longint'($signed(bs[c*PSUM_W +: PSUM_W]));
            w[c*ACT_W +: ACT_W] = model_lane(s, sh, relu);
        end
        return w;
    endfunction

    task automatic push_model(input int n, input int sh, input bit relu, input logic [ACT_AW-1:0] base);
        logic [ACT_AW-1:0] a;
        for (int p = 0; p < n; p++) begin
            a = base + ACT_AW'(p);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(model_word(mem[p], bias_in, sh, relu));
        end
    endtask

    task automatic fill_pattern(input int n);
        for (int p = 0; p < n; p++)
            for (int c = 0; c < NUM_CH; c++)
                mem[p][c*PSUM_W +: PSUM_W] = (((p * 7919 + c * 104729) % 4001) - 2000) * (c % 4 + 1);
    endtask

    // Runs one sweep and checks its cycle-level timing. Cycle 1 is the first cycle after start.
    task automatic run_sweep(input string name, input int n, input logic [4:0] sh, input bit relu,
                             input logic [ACT_AW-1:0] base, input int restart_at, input int rst_at);
        int k, wr_cnt, first_wr, last_wr, done_cyc, bad;
        logic [NUM_CH*PSUM_W-1:0] bias_save;
        bias_save = bias_in;
        @(negedge clk);
        num_pix = (RES_AW+1)'(n); shift = sh; relu_en = relu; dst_base = base; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1; wr_cnt = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
        while (k <= n + 10 && done_cyc < 0) begin
            if (k == 1) check({name, "_busy_c1"}, 128'(busy), 128'(n > 0));
            if (k <= n) check({name, "_res_addr"}, 128'(res_addr), 128'(k - 1));
            if (act_wr_we) begin
                if (first_wr < 0) first_wr = k;
                last_wr = k;
                wr_cnt++;
            end
            if (done) done_cyc = k;
            if (k == restart_at) begin
                start = 1'b1; num_pix = 2; shift = 5'd0; relu_en = ~relu;
                dst_base = base ^ 16'h5555; bias_in = ~bias_save;
            end else if (k == restart_at + 1) begin
                start = 1'b0; num_pix = (RES_AW+1)'(n); shift = sh; relu_en = relu;
                dst_base = base; bias_in = bias_save;
            end
            if (k == rst_at) begin
                #1 rst = 1'b1;
                #1;
                check({name, "_rst_we"}, 128'(act_wr_we), 128'(0));
                check({name, "_rst_busy"}, 128'(busy), 128'(0));
                check({name, "_rst_outs"}, {act_wr_data[63:0], act_wr_addr, 6'd0, res_addr, 31'd0, done}, 128'(0));
                exp_addr_q.delete();
                exp_data_q.delete();
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                bad = 0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (act_wr_we || done || busy) bad++;
                end
                check({name, "_quiet_after_rst"}, 128'(bad), 128'(0));
                return;
            end
            if (done_cyc < 0) begin
                @(negedge clk);
                k++;
            end
        end
        if (done_cyc < 0) begin
            errors++; checks++;
            $display("FAIL %s_timeout: got no done within %0d cycles, expected done", name, n + 10);
        end else begin
            check({name, "_done_cycle"}, 128'(done_cyc), 128'((n == 0) ? 1 : n + 3));
            check({name, "_busy_at_done"}, 128'(busy), 128'(0));
        end
        check({name, "_write_count"}, 128'(wr_cnt), 128'(n));
        if (n > 0) begin
            check({name, "_first_write"}, 128'(first_wr), 128'(3));
            check({name, "_last_write"}, 128'(last_wr), 128'(n + 2));
        end
        check({name, "_queue_empty"}, 128'(exp_addr_q.size()), 128'(0));
        $display("sweep %s n=%0d done_cycle=%0d writes=%0d", name, n, done_cyc, wr_cnt);
        @(negedge clk);
        check({name, "_done_one_cycle"}, 128'(done), 128'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_pix = '0; shift = '0; relu_en = 1'b0;
        bias_in = '0; dst_base = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_res_addr", 128'(res_addr), 128'(0));
        check("reset_we", 128'(act_wr_we), 128'(0));
        check("reset_addr", 128'(act_wr_addr), 128'(0));
        check("reset_data", act_wr_data, 128'(0));
        check("reset_busy_done", {busy, done}, 128'(0));
        rst = 1'b0;

        // Rounding, saturation and timing: hand-computed words, shift 3, no ReLU
        mem[0] = psum_lane(0, 1000);
        mem[1] = psum_lane(0, 2000);
        mem[2] = psum_lane(0, -2000);
        mem[3] = psum_lane(15, 7);
        exp_addr_q.push_back(16'h0100); exp_data_q.push_back(act_lane(0, 8'h7D));
        exp_addr_q.push_back(16'h0101); exp_data_q.push_back(act_lane(0, 8'h7F));
        exp_addr_q.push_back(16'h0102); exp_data_q.push_back(act_lane(0, 8'h80));
        exp_addr_q.push_back(16'h0103); exp_data_q.push_back(act_lane(15, 8'h01));
        run_sweep("timing4", 4, 5'd3, 1'b0, 16'h0100, -10, -10);

        // ReLU clamps the negative lane; positive lane unaffected
        mem[0] = psum_lane(0, -2000) | psum_lane(1, 1000);
        exp_addr_q.push_back(16'h0200); exp_data_q.push_back(act_lane(1, 8'h7D));
        run_sweep("relu", 1, 5'd3, 1'b1, 16'h0200, -10, -10);

        // Negative rounding: (-13 + 2) >>> 2 = -3
        mem[0] = psum_lane(1, -13);
        exp_addr_q.push_back(16'h0300); exp_data_q.push_back(act_lane(1, 8'hFD));
        run_sweep("neg_round", 1, 5'd2, 1'b0, 16'h0300, -10, -10);

        // Bias with shift 0: -5 + 12 = 7
        mem[0] = psum_lane(5, -5);
        bias_in = psum_lane(5, 12);
        exp_addr_q.push_back(16'h0400); exp_data_q.push_back(act_lane(5, 8'h07));
        run_sweep("bias", 1, 5'd0, 1'b0, 16'h0400, -10, -10);

        // Zero-pixel sweep: done next cycle, no writes
        run_sweep("zero", 0, 5'd3, 1'b0, 16'h0500, -10, -10);

        // 5x5 output, all lanes with per-lane bias, against the model
        fill_pattern(25);
        for (int c = 0; c < NUM_CH; c++) bias_in[c*PSUM_W +: PSUM_W] = (c - 8) * 50;
        push_model(25, 5, 1'b0, 16'h0040);
        run_sweep("pix25", 25, 5'd5, 1'b0, 16'h0040, -10, -10);
        push_model(25, 4, 1'b1, 16'h0800);
        run_sweep("pix25_relu", 25, 5'd4, 1'b1, 16'h0800, -10, -10);

        // A second start while busy is ignored
        push_model(8, 3, 1'b0, 16'h0900);
        run_sweep("restart", 8, 5'd3, 1'b0, 16'h0900, 3, -10);

        // Destination address wraps
        push_model(3, 2, 1'b0, 16'hFFFE);
        run_sweep("wrap", 3, 5'd2, 1'b0, 16'hFFFE, -10, -10);

        // Reset while pixel 10 is written, then a fresh sweep
        push_model(25, 5, 1'b0, 16'h0A00);
        run_sweep("midrst", 25, 5'd5, 1'b0, 16'h0A00, -10, 13);
        push_model(25, 5, 1'b0, 16'h0A00);
        run_sweep("after_rst", 25, 5'd5, 1'b0, 16'h0A00, -10, -10);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_requant_writeback.md
Name: psum_requant_writeback

Overview:
- Downstream consumer of the PE system result port. After a convolution completes, it sweeps the partial-sum buffer one output pixel at a time.
- For each pixel it adds a per-channel bias, applies a rounding arithmetic right shift and optional ReLU, and saturates to int8.
- It packs the 16 channel results into one 128-bit word and writes that word into an activation buffer for the next layer.
- Pipelined at one pixel per cycle.

Parameters:
- NUM_CH, 16, channel lanes per pixel.
- PSUM_W, 32, signed partial-sum width per lane.
- ACT_W, 8, signed output activation width per lane.
- RES_AW, 10, partial-sum buffer address width.
- ACT_AW, 16, destination activation buffer address width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- num_pix  in  RES_AW+1  pixels to process (OUT_H*OUT_W); sampled on start.
- shift  in  5  right-shift amount 0..31; sampled on start.
- relu_en  in  1  clamp negatives to 0; sampled on start.
- bias_in  in  NUM_CH*PSUM_W  signed per-lane bias, lane c at [c*PSUM_W +: PSUM_W]; sampled on start.
- dst_base  in  ACT_AW  first destination address; sampled on start.
- res_addr  out  RES_AW  partial-sum buffer read address.
- res_data  in  NUM_CH*PSUM_W  read data, valid exactly one cycle after res_addr.
- act_wr_we  out  1  destination write enable.
- act_wr_addr  out  ACT_AW  destination address.
- act_wr_data  out  NUM_CH*ACT_W  packed int8 result, lane c at [c*ACT_W +: ACT_W].
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: res_addr=0, act_wr_we=0, act_wr_addr=0, act_wr_data=0, busy=0, done=0. All pipeline valids are cleared.
- States:
  - IDLE: accepts start. With num_pix=0 it goes to FIN; otherwise to ISSUE.
  - ISSUE: res_addr counts 0..num_pix-1, one per cycle. It goes to DRAIN after the last address.
  - DRAIN: waits for pipeline valids to empty, then goes to FIN.
  - FIN: done=1 for one cycle, then returns to IDLE.
- start in any state other than IDLE is ignored. Configuration is latched only on an accepted start.
- Pipeline: address p is issued in cycle t.
  - S1 (edge ending t+1): sum_c = res_data_c + bias_c, 33-bit signed.
  - S2 (edge ending t+2): r_c = (sum_c + (shift>0 ? 2^(shift-1) : 0)) >>> shift, 34-bit arithmetic. This is round-half-up.
  - S2 then applies relu_en (r_c<0 gives 0) and saturates to [-128,127].
- act_wr_we for pixel p is high during cycle t+2, with act_wr_addr = dst_base+p. The address wraps modulo 2^ACT_AW.
- Writes are contiguous, one per cycle, with no gaps.
- done pulses the cycle after the last write. busy drops in that same cycle.
- All NUM_CH lanes are processed regardless of the active output-channel count. Unused lanes carry whatever the buffer holds.
- Reset mid-sweep: outputs return to their reset values immediately (asynchronously). No further writes occur and done does not pulse. A new start is required.
- num_pix above 2^RES_AW is clamped to 2^RES_AW.

Test Plan:
- Basic rounding: lane0 psum=1000, bias=0, shift=3, relu off -> act_wr_data[7:0]=0x7D (125). Lane1 psum=-13, shift=2 -> 0xFD (-3).
- Saturation and ReLU: psum=2000 at shift=3 -> 0x7F. psum=-2000 at shift=3 -> 0x80 with relu off, 0x00 with relu on.
- Bias: lane5 psum=-5, bias=12, shift=0 -> 0x07. Check all 16 lanes against a bench model.
- Sweep timing: num_pix=4, dst_base=0x0100.
  - res_addr=0,1,2,3 in consecutive cycles.
  - act_wr_we high 2 cycles after res_addr=0, for 4 consecutive cycles, at addresses 0x0100..0x0103.
  - done pulses 1 cycle after the last write.
  - Also run num_pix=25 (a 5x5 output) and compare all pixels against the bench model.
- Edge cases:
  - num_pix=0 -> done pulses the next cycle with no writes.
  - A second start while busy does not restart res_addr or change the latched shift.
  - dst_base=0xFFFE with num_pix=3 -> writes to 0xFFFE, 0xFFFF, 0x0000.
- Reset mid-run: assert rst at pixel 10 of 25 -> act_wr_we=0 and busy=0 immediately, and done never pulses. A fresh start then completes all 25 writes correctly.
